// File: rtl/tpa_reg_arbiter_pkg.sv
// Shared types and constants for the register-bank arbiter: default widths,
// FSM state encoding and requester-select values.
package tpa_reg_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int WAIT_W     = 4;
  localparam int STAT_W     = 16;
  localparam int STAT_MAX   = 65535;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_t;

  localparam logic SEL_H = 1'b0;
  localparam logic SEL_S = 1'b1;

endpackage

// File: rtl/tpa_arb_age_cnt.sv
// Saturating up-counter with synchronous clear and an at-limit flag; used as
// the serial starvation counter and as the optional statistics counters.
module tpa_arb_age_cnt #(
  parameter int W   = 4,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/tpa_reg_arbiter.sv
// Two-requester arbiter for a single-port register bank: host priority, serial
// aging override and host-wins write collisions. Optional statistics counters
// are built when TPA_ARB_STATS_EN is defined.
module tpa_reg_arbiter
  import tpa_reg_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              h_req,
  input  logic              h_cmd,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_rdy,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              s_req,
  input  logic              s_cmd,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_ack,
  output logic              s_drop,
  output logic [DATA_W-1:0] s_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef TPA_ARB_STATS_EN
  output logic [STAT_W-1:0] stat_h_grants,
  output logic [STAT_W-1:0] stat_s_grants,
  output logic [STAT_W-1:0] stat_drops,
`endif
  output logic [1:0]        dbg_state,
  output logic [WAIT_W-1:0] dbg_wait_cnt
);

  // Handshake: a requester raises req with cmd/addr/wdata and holds all of them
  // stable until its one-cycle rdy/ack pulse; it may drop req in that cycle.

  arb_state_t        state_q, state_d;
  logic              sel_q, sel_d;
  logic              collide_q;
  logic [DATA_W-1:0] h_rdata_q, s_rdata_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              aged;
  logic              s_pick;
  logic              h_grant, s_grant;
  logic              collide;

  assign s_pick  = s_req && (!h_req || aged);
  assign h_grant = (state_q == ST_GRANT) && (sel_q == SEL_H);
  assign s_grant = (state_q == ST_GRANT) && (sel_q == SEL_S);
  assign collide = h_grant && h_cmd && s_req && s_cmd && (s_addr == h_addr);

  // Counts host grants taken while the serial side waits; clears once serial
  // is served or stops asking.
  tpa_arb_age_cnt #(
    .W   (WAIT_W),
    .MAX (MAX_WAIT)
  ) u_age_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!s_req || s_grant),
    .inc     (h_grant && s_req),
    .cnt     (wait_cnt),
    .at_max  (aged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= SEL_H;
      collide_q <= 1'b0;
      h_rdata_q <= '0;
      s_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      if (state_q == ST_GRANT) begin
        collide_q <= collide;
      end
      h_rdata_q <= h_rdata;
      s_rdata_q <= s_rdata;
    end
  end

  // Arbitration happens only in IDLE, so a requester whose pulse is in the
  // current (DONE) cycle can never be re-granted in that same cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (h_req || s_req) begin
          state_d = ST_GRANT;
          sel_d   = s_pick ? SEL_S : SEL_H;
        end
      end
      ST_GRANT: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    h_rdy     = 1'b0;
    s_ack     = 1'b0;
    s_drop    = 1'b0;
    h_rdata   = h_rdata_q;
    s_rdata   = s_rdata_q;
    case (state_q)
      ST_GRANT: begin
        mem_en = 1'b1;
        if (sel_q == SEL_S) begin
          mem_we    = s_cmd;
          mem_addr  = s_addr;
          mem_wdata = s_wdata;
        end else begin
          mem_we    = h_cmd;
          mem_addr  = h_addr;
          mem_wdata = h_wdata;
        end
      end
      ST_DONE: begin
        if (sel_q == SEL_H) begin
          h_rdy = 1'b1;
          if (!h_cmd) begin
            h_rdata = mem_rdata;
          end
          // The cancelled serial write completes alongside the host write.
          if (collide_q) begin
            s_ack  = 1'b1;
            s_drop = 1'b1;
          end
        end else begin
          s_ack = 1'b1;
          if (!s_cmd) begin
            s_rdata = mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  assign dbg_state    = state_q;
  assign dbg_wait_cnt = wait_cnt;

`ifdef TPA_ARB_STATS_EN
  logic stat_h_sat, stat_s_sat, stat_d_sat;

  tpa_arb_age_cnt #(.W(STAT_W), .MAX(STAT_MAX)) u_stat_h (
    .clk (clk), .reset_n (reset_n), .clr (1'b0),
    .inc (h_grant && !stat_h_sat), .cnt (stat_h_grants), .at_max (stat_h_sat)
  );

  tpa_arb_age_cnt #(.W(STAT_W), .MAX(STAT_MAX)) u_stat_s (
    .clk (clk), .reset_n (reset_n), .clr (1'b0),
    .inc (s_grant && !stat_s_sat), .cnt (stat_s_grants), .at_max (stat_s_sat)
  );

  tpa_arb_age_cnt #(.W(STAT_W), .MAX(STAT_MAX)) u_stat_d (
    .clk (clk), .reset_n (reset_n), .clr (1'b0),
    .inc (s_drop && !stat_d_sat), .cnt (stat_drops), .at_max (stat_d_sat)
  );
`endif

  a_h_hold: assert property (@(posedge clk) disable iff (!reset_n) h_grant |-> h_req);
  a_s_hold: assert property (@(posedge clk) disable iff (!reset_n) s_grant |-> s_req);
  a_drop_pair: assert property (@(posedge clk) disable iff (!reset_n) s_drop |-> (s_ack && h_rdy));

endmodule

// File: tb/tb_tpa_reg_arbiter.sv
// Self-checking bench for tpa_reg_arbiter: directed and randomized accesses
// checked against a transaction-level model of the arbitration rules.
module tb_tpa_reg_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        h_req = 1'b0, h_cmd = 1'b0;
  logic [7:0]  h_addr = '0;
  logic [15:0] h_wdata = '0;
  logic        s_req = 1'b0, s_cmd = 1'b0;
  logic [7:0]  s_addr = '0;
  logic [15:0] s_wdata = '0;
  logic        h_rdy, s_ack, s_drop, mem_en, mem_we;
  logic [15:0] h_rdata, s_rdata, mem_wdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_wait_cnt;
`ifdef TPA_ARB_STATS_EN
  logic [15:0] stat_h_grants, stat_s_grants, stat_drops;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_bank [256];
  logic [15:0] stor [256];
  bit          vld [256];
  logic [15:0] hold_h = '0;
  logic [15:0] hold_s = '0;
  int exp_hg = 0, exp_sg = 0, exp_dr = 0;

  tpa_reg_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk), .reset_n (reset_n),
    .h_req (h_req), .h_cmd (h_cmd), .h_addr (h_addr), .h_wdata (h_wdata),
    .h_rdy (h_rdy), .h_rdata (h_rdata),
    .s_req (s_req), .s_cmd (s_cmd), .s_addr (s_addr), .s_wdata (s_wdata),
    .s_ack (s_ack), .s_drop (s_drop), .s_rdata (s_rdata),
    .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_rdata (mem_rdata),
`ifdef TPA_ARB_STATS_EN
    .stat_h_grants (stat_h_grants), .stat_s_grants (stat_s_grants), .stat_drops (stat_drops),
`endif
    .dbg_state (dbg_state), .dbg_wait_cnt (dbg_wait_cnt)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return {a, ~a} ^ 16'h3C5A;
  endfunction

  // Register storage: registered read, one cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        stor[mem_addr] <= mem_wdata;
        vld[mem_addr]  <= 1'b1;
      end
      mem_rdata <= vld[mem_addr] ? stor[mem_addr] : init_val(mem_addr);
    end
  end

  function automatic logic [7:0] pick_addr();
    logic [7:0] a;
    case ($urandom_range(0, 3))
      0:       a = 8'h00;
      1:       a = 8'h01;
      2:       a = 8'hFE;
      default: a = 8'hFF;
    endcase
    return a;
  endfunction

  // One transaction pair launched from IDLE; H and/or S start in the same cycle.
  task automatic do_txn(input string name,
                        input bit h_en, input bit hc, input logic [7:0] ha, input logic [15:0] hw,
                        input bit s_en, input bit sc, input logic [7:0] sa, input logic [15:0] sw);
    int exp_hn, exp_sn, exp_we, got_hn, got_sn, we_cnt, h_pulses, s_pulses;
    bit drop, got_drop;
    logic [15:0] got_hr, got_sr;
    drop   = h_en && s_en && hc && sc && (ha == sa);
    exp_hn = h_en ? 2 : 0;
    exp_sn = !s_en ? 0 : ((h_en && !drop) ? 5 : 2);
    exp_we = ((h_en && hc) ? 1 : 0) + ((s_en && sc && !drop) ? 1 : 0);
    if (h_en) begin
      exp_hg++;
      if (hc) exp_bank[ha] = hw;
      else    hold_h = exp_bank[ha];
    end
    if (drop) exp_dr++;
    if (s_en && !drop) begin
      exp_sg++;
      if (sc) exp_bank[sa] = sw;
      else    hold_s = exp_bank[sa];
    end
    got_hn = 0; got_sn = 0; we_cnt = 0; h_pulses = 0; s_pulses = 0;
    got_drop = 1'b0; got_hr = '0; got_sr = '0;
    h_req = h_en; h_cmd = hc; h_addr = ha; h_wdata = hw;
    s_req = s_en; s_cmd = sc; s_addr = sa; s_wdata = sw;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (h_rdy) begin
        h_pulses++; got_hn = n; got_hr = h_rdata; h_req = 1'b0;
      end
      if (s_ack) begin
        s_pulses++; got_sn = n; got_drop = s_drop; got_sr = s_rdata; s_req = 1'b0;
      end
    end
    checks++;
    if (h_pulses !== (h_en ? 1 : 0)) begin
      errors++; $display("FAIL %s h_rdy_count got=%0d exp=%0d", name, h_pulses, h_en ? 1 : 0);
    end
    checks++;
    if (s_pulses !== (s_en ? 1 : 0)) begin
      errors++; $display("FAIL %s s_ack_count got=%0d exp=%0d", name, s_pulses, s_en ? 1 : 0);
    end
    checks++;
    if (got_hn !== exp_hn) begin
      errors++; $display("FAIL %s h_latency got=%0d exp=%0d", name, got_hn, exp_hn);
    end
    checks++;
    if (got_sn !== exp_sn) begin
      errors++; $display("FAIL %s s_latency got=%0d exp=%0d", name, got_sn, exp_sn);
    end
    checks++;
    if (got_drop !== drop) begin
      errors++; $display("FAIL %s s_drop got=%0b exp=%0b", name, got_drop, drop);
    end
    checks++;
    if (we_cnt !== exp_we) begin
      errors++; $display("FAIL %s mem_we_cycles got=%0d exp=%0d", name, we_cnt, exp_we);
    end
    if (h_en) begin
      checks++;
      if (got_hr !== hold_h) begin
        errors++; $display("FAIL %s h_rdata got=%h exp=%h", name, got_hr, hold_h);
      end
    end
    if (s_en) begin
      checks++;
      if (got_sr !== hold_s) begin
        errors++; $display("FAIL %s s_rdata got=%h exp=%h", name, got_sr, hold_s);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({h_rdy, s_ack, s_drop, mem_en, mem_we} !== 5'b0 || mem_addr !== 8'h00 ||
        mem_wdata !== 16'h0 || h_rdata !== 16'h0 || s_rdata !== 16'h0 ||
        dbg_state !== 2'd0 || dbg_wait_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs got ctl=%b addr=%h wd=%h hr=%h sr=%h st=%0d wc=%0d exp all zero",
               {h_rdy, s_ack, s_drop, mem_en, mem_we}, mem_addr, mem_wdata, h_rdata, s_rdata,
               dbg_state, dbg_wait_cnt);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL reset_idle got state=%0d mem_en=%b exp state=0 mem_en=0", dbg_state, mem_en);
    end
  endtask

  task automatic test_host_rw();
    do_txn("h_write_10", 1, 1, 8'h10, 16'h1234, 0, 0, 8'h00, 16'h0);
    do_txn("h_read_10",  1, 0, 8'h10, 16'h0,    0, 0, 8'h00, 16'h0);
  endtask

  task automatic test_serial_rw();
    do_txn("s_write_20", 0, 0, 8'h00, 16'h0, 1, 1, 8'h20, 16'hBEEF);
    do_txn("s_read_20",  0, 0, 8'h00, 16'h0, 1, 0, 8'h20, 16'h0);
  endtask

  task automatic test_collision();
    do_txn("collide_80", 1, 1, 8'h80, 16'hAAAA, 1, 1, 8'h80, 16'h5555);
    do_txn("s_read_80",  0, 0, 8'h00, 16'h0,    1, 0, 8'h80, 16'h0);
  endtask

  task automatic test_adjacent();
    do_txn("hw80_sw81", 1, 1, 8'h80, 16'h1111, 1, 1, 8'h81, 16'h2222);
    do_txn("hr80_sr81", 1, 0, 8'h80, 16'h0,    1, 0, 8'h81, 16'h0);
  endtask

  task automatic test_same_addr();
    do_txn("hw_sr_same", 1, 1, 8'h90, 16'h7E57, 1, 0, 8'h90, 16'h0);
    do_txn("hr_sr_same", 1, 0, 8'h90, 16'h0,    1, 0, 8'h90, 16'h0);
    do_txn("hr_sw_same", 1, 0, 8'h91, 16'h0,    1, 1, 8'h91, 16'h4321);
  endtask

  task automatic test_boundary();
    do_txn("hw_ff_sw_00", 1, 1, 8'hFF, 16'hF00F, 1, 1, 8'h00, 16'h0FF0);
    do_txn("hr_00_sr_ff", 1, 0, 8'h00, 16'h0,    1, 0, 8'hFF, 16'h0);
  endtask

  task automatic test_random();
    int kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      do_txn("random", kind != 1, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom),
             kind != 0, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
    end
  endtask

  // Host streams six writes while a serial read waits; aging forces S in.
  task automatic test_starvation();
    logic [7:0]  ha [6];
    logic [15:0] hw [6];
    logic [7:0]  sa;
    logic [15:0] exp_sr, ev, got;
    int hi, age, n, nh, a;
    bit s_pend;
    int age_q[$];
    for (int i = 0; i < 6; i++) begin
      ha[i] = 8'($urandom_range(8'h40, 8'h47));
      hw[i] = 16'($urandom);
    end
    sa = ha[1];
    exp_sr = '0;
    hi = 0; age = 0; s_pend = 1'b1; n = 2;
    exp_q.delete();
    while (hi < 6 || s_pend) begin
      if (s_pend && (hi >= 6 || age == MAX_WAIT)) begin
        exp_q.push_back(16'h0100 | 16'(n));
        age_q.push_back(0);
        exp_sr = exp_bank[sa];
        s_pend = 1'b0; age = 0; exp_sg++;
      end else begin
        exp_bank[ha[hi]] = hw[hi];
        if (s_pend && age < MAX_WAIT) age++;
        exp_q.push_back(16'(n));
        age_q.push_back(age);
        hi++; exp_hg++;
      end
      n += 3;
    end
    hold_s = exp_sr;
    nh = 0;
    h_req = 1'b1; h_cmd = 1'b1; h_addr = ha[0]; h_wdata = hw[0];
    s_req = 1'b1; s_cmd = 1'b0; s_addr = sa; s_wdata = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (h_rdy || s_ack) begin
        got = 16'(c) | (s_ack ? 16'h0100 : 16'h0000);
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL starve_extra completion tag=%h exp none", got);
        end else begin
          ev = exp_q.pop_front();
          a = age_q.pop_front();
          if (got !== ev) begin
            errors++; $display("FAIL starve_order got=%h exp=%h", got, ev);
          end
          checks++;
          if (dbg_wait_cnt !== 4'(a)) begin
            errors++; $display("FAIL starve_wait_cnt cycle=%0d got=%0d exp=%0d", c, dbg_wait_cnt, a);
          end
        end
        if (s_ack) begin
          checks++;
          if (s_rdata !== exp_sr || s_drop !== 1'b0) begin
            errors++; $display("FAIL starve_s_read got=%h drop=%b exp=%h drop=0", s_rdata, s_drop, exp_sr);
          end
          s_req = 1'b0;
        end
        if (h_rdy) begin
          nh++;
          if (nh < 6) begin
            h_addr = ha[nh]; h_wdata = hw[nh];
          end else begin
            h_req = 1'b0;
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL starve_missing got=%0d pending exp=0", exp_q.size());
    end
    do_txn("starve_readback", 1, 0, ha[5], 16'h0, 1, 0, ha[0], 16'h0);
  endtask

`ifdef TPA_ARB_STATS_EN
  task automatic test_stats();
    checks++;
    if (stat_h_grants !== 16'(exp_hg) || stat_s_grants !== 16'(exp_sg) || stat_drops !== 16'(exp_dr)) begin
      errors++;
      $display("FAIL stats got h=%0d s=%0d d=%0d exp h=%0d s=%0d d=%0d",
               stat_h_grants, stat_s_grants, stat_drops, exp_hg, exp_sg, exp_dr);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int acks;
    s_req = 1'b1; s_cmd = 1'b1; s_addr = 8'h33; s_wdata = 16'hC0DE;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h33) begin
      errors++; $display("FAIL rst_grant got en=%b we=%b addr=%h exp en=1 we=1 addr=33", mem_en, mem_we, mem_addr);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({h_rdy, s_ack, s_drop, mem_en, mem_we} !== 5'b0 || mem_addr !== 8'h00 ||
        mem_wdata !== 16'h0 || h_rdata !== 16'h0 || s_rdata !== 16'h0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs got ctl=%b addr=%h wd=%h hr=%h sr=%h st=%0d exp all zero",
               {h_rdy, s_ack, s_drop, mem_en, mem_we}, mem_addr, mem_wdata, h_rdata, s_rdata, dbg_state);
    end
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (s_ack) acks++;
      s_req = 1'b0;
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL rst_no_ack got=%0d exp=0", acks);
    end
    reset_n = 1'b1;
    hold_h = '0; hold_s = '0;
    exp_hg = 0; exp_sg = 0; exp_dr = 0;
    @(negedge clk);
`ifdef TPA_ARB_STATS_EN
    test_stats();
`endif
    do_txn("rst_h_read", 1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_bank[i] = init_val(8'(i));
    test_reset();
    test_host_rw();
    test_serial_rw();
    test_collision();
    test_adjacent();
    test_same_addr();
    test_boundary();
    test_random();
    test_starvation();
`ifdef TPA_ARB_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
